// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 states, sizes and key byte selection
package arc4_pkg;
    localparam int KEY_BYTES = 3;
    localparam int S_DEPTH   = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_LEN,
        ST_PRGA
    } arc4_state_t;

    // Sub-steps of one KSA or PRGA iteration over the S RAM
    typedef enum logic [2:0] {
        STEP_RI,
        STEP_RJ,
        STEP_WI,
        STEP_WJ,
        STEP_RP,
        STEP_OUT
    } ks_step_t;

    // Key byte 0 is the most significant byte of the key word
    function automatic logic [7:0] keybyte(input logic [8*KEY_BYTES-1:0] key, input logic [7:0] idx);
        logic [7:0]             n;
        logic [8*KEY_BYTES-1:0] sh;
        n  = idx % 8'(KEY_BYTES);
        sh = key >> (8 * (KEY_BYTES - 1 - int'(n)));
        return sh[7:0];
    endfunction
endpackage

// File: rtl/arc4_keystream.sv
// rtl/arc4_keystream.sv - S-box init, key schedule and pad generation over an external S RAM
module arc4_keystream
    import arc4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output arc4_state_t            phase,
    output logic [7:0]             pad_tdata,
    output logic                   pad_tvalid,
    input  logic                   pad_tready,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata
);
    arc4_state_t state, state_n;
    ks_step_t    step, step_n;
    logic [7:0]  i, i_n, j, j_n, si, si_n, sj, sj_n;
    logic [7:0]  j_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= STEP_RI;
            i     <= 8'd0;
            j     <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
        end else begin
            state <= state_n;
            step  <= step_n;
            i     <= i_n;
            j     <= j_n;
            si    <= si_n;
            sj    <= sj_n;
        end
    end

    always_comb begin
        state_n    = state;
        step_n     = step;
        i_n        = i;
        j_n        = j;
        si_n       = si;
        sj_n       = sj;
        s_addr     = 8'd0;
        s_wrdata   = 8'd0;
        s_wren     = 1'b0;
        pad_tdata  = 8'd0;
        pad_tvalid = 1'b0;
        j_sum      = j + s_rddata + ((state == ST_KSA) ? keybyte(key, i) : 8'd0);
        if (start) begin
            state_n = ST_INIT;
            step_n  = STEP_RI;
            i_n     = 8'd0;
            j_n     = 8'd0;
        end else begin
            case (state)
                ST_INIT: begin
                    s_addr   = i;
                    s_wrdata = i;
                    s_wren   = 1'b1;
                    i_n      = i + 8'd1;
                    if (i == 8'hFF) state_n = ST_KSA;
                end
                ST_KSA, ST_PRGA: begin
                    case (step)
                        STEP_RI: begin
                            s_addr = i;
                            step_n = STEP_RJ;
                        end
                        STEP_RJ: begin
                            s_addr = j_sum;
                            j_n    = j_sum;
                            si_n   = s_rddata;
                            step_n = STEP_WI;
                        end
                        STEP_WI: begin
                            s_addr   = i;
                            s_wrdata = s_rddata;
                            s_wren   = 1'b1;
                            sj_n     = s_rddata;
                            step_n   = STEP_WJ;
                        end
                        STEP_WJ: begin
                            s_addr   = j;
                            s_wrdata = si;
                            s_wren   = 1'b1;
                            if (state == ST_KSA) begin
                                step_n = STEP_RI;
                                if (i == 8'hFF) begin
                                    state_n = ST_LEN;
                                    i_n     = 8'd0;
                                    j_n     = 8'd0;
                                end else begin
                                    i_n = i + 8'd1;
                                end
                            end else begin
                                step_n = STEP_RP;
                            end
                        end
                        STEP_RP: begin
                            s_addr = si + sj;
                            step_n = STEP_OUT;
                        end
                        STEP_OUT: begin
                            // Address held so the pad stays valid while the consumer stalls
                            s_addr     = si + sj;
                            pad_tdata  = s_rddata;
                            pad_tvalid = 1'b1;
                            if (pad_tready) begin
                                state_n = ST_LEN;
                                step_n  = STEP_RI;
                            end
                        end
                        default: step_n = STEP_RI;
                    endcase
                end
                ST_LEN: begin
                    if (pad_tready) begin
                        i_n     = i + 8'd1;
                        state_n = ST_PRGA;
                        step_n  = STEP_RI;
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase = state;
endmodule

// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - length-framed ARC4 encryptor from pt memory into ct memory
module arc4_encrypt
    import arc4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);
    arc4_state_t            state, state_n, phase;
    logic [7:0]             k, k_n, len, len_n;
    logic [8*KEY_BYTES-1:0] key_q, key_n;
    logic                   ks_start, pad_tvalid, pad_tready;
    logic [7:0]             pad_tdata;

    arc4_keystream u_keystream (
        .clk        (clk),
        .rst        (rst),
        .start      (ks_start),
        .key        (key_q),
        .phase      (phase),
        .pad_tdata  (pad_tdata),
        .pad_tvalid (pad_tvalid),
        .pad_tready (pad_tready),
        .s_addr     (s_addr),
        .s_wrdata   (s_wrdata),
        .s_wren     (s_wren),
        .s_rddata   (s_rddata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= 8'd0;
            len   <= 8'd0;
            key_q <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            len   <= len_n;
            key_q <= key_n;
        end
    end

    // pt_addr follows k, so pt[k] has settled long before its pad arrives
    always_comb begin
        state_n    = state;
        k_n        = k;
        len_n      = len;
        key_n      = key_q;
        ks_start   = 1'b0;
        pad_tready = 1'b0;
        ct_addr    = 8'd0;
        ct_wrdata  = 8'd0;
        ct_wren    = 1'b0;
        rdy        = (state == ST_IDLE);
        pt_addr    = k;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    ks_start = 1'b1;
                    key_n    = key;
                    k_n      = 8'd0;
                    state_n  = ST_INIT;
                end
            end
            ST_INIT: if (phase == ST_KSA) state_n = ST_KSA;
            ST_KSA:  if (phase == ST_LEN) state_n = ST_LEN;
            ST_LEN: begin
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                len_n     = pt_rddata;
                k_n       = 8'd1;
                state_n   = (pt_rddata == 8'd0) ? ST_IDLE : ST_PRGA;
            end
            ST_PRGA: begin
                pad_tready = 1'b1;
                ct_addr    = k;
                ct_wrdata  = pt_rddata ^ pad_tdata;
                ct_wren    = pad_tvalid;
                if (pad_tvalid) begin
                    if (k == len) state_n = ST_IDLE;
                    else          k_n     = k + 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb/tb_arc4_encrypt.sv - directed self-checking bench for arc4_encrypt
module tb_arc4_encrypt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rdy;
    logic [23:0] key = 24'h0;
    logic [7:0]  s_addr, s_rddata, s_wrdata, pt_addr, pt_rddata, ct_addr, ct_wrdata;
    logic        s_wren, ct_wren;
    logic        ct_clear = 1'b0;

    logic [7:0] s_mem  [0:255];
    logic [7:0] pt_mem [0:255];
    logic [7:0] ct_mem [0:255];
    logic [7:0] exp_ct [0:9];
    logic [7:0] pt_known [0:8];
    logic [7:0] orig [0:255];
    logic [7:0] first [0:9];

    int n_checks = 0;
    int n_fail = 0;
    int ct_pulses = 0;
    int s_pulses = 0;
    int overlap = 0;
    int range_viol = 0;

    arc4_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (ct_clear) begin
            for (int a = 0; a < 256; a++) ct_mem[a] <= 8'hAA;
        end else if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
        end
    end

    always @(negedge clk) begin
        if (ct_wren) ct_pulses <= ct_pulses + 1;
        if (s_wren) s_pulses <= s_pulses + 1;
        if (s_wren && ct_wren) overlap <= overlap + 1;
        if (ct_wren && ct_addr > pt_mem[0]) range_viol <= range_viol + 1;
    end

    task automatic load_known();
        pt_mem[0] = 8'd9;
        for (int n = 0; n < 9; n++) pt_mem[n+1] = pt_known[n];
    endtask

    task automatic clear_ct();
        @(negedge clk);
        ct_clear = 1'b1;
        @(negedge clk);
        ct_clear = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] k);
        @(negedge clk);
        key = k;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
    endtask

    task automatic wait_done(input int len, output bit ok, output int cyc);
        int budget;
        budget = 256 + 256*6 + 3 + len*9;
        cyc = 1;
        while (rdy !== 1'b1 && cyc <= budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = (rdy === 1'b1) && (cyc <= budget);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", rdy); end
        n_checks++; if ({s_wren, ct_wren} !== 2'b00) begin n_fail++; $display("FAIL reset_wren got %b want 00", {s_wren, ct_wren}); end
        n_checks++; if ({s_addr, pt_addr, ct_addr} !== 24'h0) begin n_fail++; $display("FAIL reset_addr got %h want 000000", {s_addr, pt_addr, ct_addr}); end
        n_checks++; if ({s_wrdata, ct_wrdata} !== 16'h0) begin n_fail++; $display("FAIL reset_wrdata got %h want 0000", {s_wrdata, ct_wrdata}); end
        rst = 1'b0;
    endtask

    task automatic test_known_vector();
        int c0, cyc;
        bit ok;
        load_known();
        clear_ct();
        c0 = ct_pulses;
        start_run(24'h4B6579);
        wait_done(9, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL known_done got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        for (int n = 0; n < 10; n++) begin
            n_checks++; if (ct_mem[n] !== exp_ct[n]) begin n_fail++; $display("FAIL known_ct[%0d] got %h want %h", n, ct_mem[n], exp_ct[n]); end
        end
        n_checks++; if (ct_pulses - c0 !== 10) begin n_fail++; $display("FAIL known_pulses got %0d want 10", ct_pulses - c0); end
    endtask

    task automatic test_zero_length();
        int c0, s0, cyc;
        bit ok;
        pt_mem[0] = 8'h00;
        clear_ct();
        c0 = ct_pulses;
        s0 = s_pulses;
        start_run(24'h4B6579);
        wait_done(0, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_done got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        n_checks++; if (ct_mem[0] !== 8'h00) begin n_fail++; $display("FAIL zero_ct0 got %h want 00", ct_mem[0]); end
        n_checks++; if (ct_mem[1] !== 8'hAA) begin n_fail++; $display("FAIL zero_ct1 got %h want AA", ct_mem[1]); end
        n_checks++; if (ct_pulses - c0 !== 1) begin n_fail++; $display("FAIL zero_ct_pulses got %0d want 1", ct_pulses - c0); end
        n_checks++; if (s_pulses - s0 !== 768) begin n_fail++; $display("FAIL zero_s_pulses got %0d want 768", s_pulses - s0); end
    endtask

    task automatic test_round_trip();
        int cyc, bad;
        bit ok;
        pt_mem[0] = 8'hFF;
        orig[0]   = 8'hFF;
        for (int n = 1; n < 256; n++) begin
            orig[n]   = 8'($urandom_range(0, 255));
            pt_mem[n] = orig[n];
        end
        start_run(24'h1E4600);
        wait_done(255, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rt_done1 got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        for (int n = 0; n < 256; n++) pt_mem[n] = ct_mem[n];
        clear_ct();
        start_run(24'h1E4600);
        wait_done(255, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rt_done2 got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        bad = 0;
        for (int n = 0; n < 256; n++) begin
            if (ct_mem[n] !== orig[n]) begin
                if (bad < 4) $display("FAIL rt_byte[%0d] got %h want %h", n, ct_mem[n], orig[n]);
                bad++;
            end
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rt_total got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_busy_en();
        int c0, cyc;
        bit ok;
        load_known();
        clear_ct();
        c0 = ct_pulses;
        start_run(24'h4B6579);
        repeat (400) @(negedge clk);
        key = 24'hFFFFFF;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL busy_rdy got %b want 0", rdy); end
        wait_done(9, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_done got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        for (int n = 0; n < 10; n++) begin
            n_checks++; if (ct_mem[n] !== exp_ct[n]) begin n_fail++; $display("FAIL busy_ct[%0d] got %h want %h", n, ct_mem[n], exp_ct[n]); end
        end
        n_checks++; if (ct_pulses - c0 !== 10) begin n_fail++; $display("FAIL busy_pulses got %0d want 10", ct_pulses - c0); end
    endtask

    task automatic test_mid_reset();
        int cyc;
        bit ok, found;
        load_known();
        clear_ct();
        start_run(24'h4B6579);
        found = 1'b0;
        for (int t = 0; t < 3000 && !found; t++) begin
            @(negedge clk);
            if (ct_wren === 1'b1 && ct_addr === 8'd4) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reach_k4 got none want ct write at 4"); end
        rst = 1'b1;
        #1;
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mid_async_rdy got %b want 1", rdy); end
        n_checks++; if (ct_wren !== 1'b0) begin n_fail++; $display("FAIL mid_async_ct_wren got %b want 0", ct_wren); end
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (ct_mem[3] !== exp_ct[3]) begin n_fail++; $display("FAIL mid_ct3 got %h want %h", ct_mem[3], exp_ct[3]); end
        n_checks++; if (ct_mem[4] !== 8'hAA) begin n_fail++; $display("FAIL mid_ct4 got %h want AA", ct_mem[4]); end
        clear_ct();
        start_run(24'h4B6579);
        wait_done(9, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_done got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        for (int n = 0; n < 10; n++) begin
            n_checks++; if (ct_mem[n] !== exp_ct[n]) begin n_fail++; $display("FAIL mid_ct[%0d] got %h want %h", n, ct_mem[n], exp_ct[n]); end
        end
    endtask

    task automatic test_back_to_back();
        int c0, cyc;
        bit ok;
        load_known();
        clear_ct();
        start_run(24'h4B6579);
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got rdy=%b want 1", rdy); end
        for (int n = 0; n < 10; n++) first[n] = ct_mem[n];
        c0  = ct_pulses;
        key = 24'h4B6579;
        en  = 1'b1;
        @(negedge clk);
        en  = 1'b0;
        n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got rdy=%b want 0", rdy); end
        wait_done(9, ok, cyc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got rdy=%b after %0d cycles want rdy=1", rdy, cyc); end
        n_checks++; if (ct_pulses - c0 !== 10) begin n_fail++; $display("FAIL b2b_pulses got %0d want 10", ct_pulses - c0); end
        for (int n = 0; n < 10; n++) begin
            n_checks++; if (first[n] !== exp_ct[n]) begin n_fail++; $display("FAIL b2b_first[%0d] got %h want %h", n, first[n], exp_ct[n]); end
            n_checks++; if (ct_mem[n] !== first[n]) begin n_fail++; $display("FAIL b2b_second[%0d] got %h want %h", n, ct_mem[n], first[n]); end
        end
    endtask

    task automatic test_write_rules();
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL rule_overlap got %0d cycles want 0", overlap); end
        n_checks++; if (range_viol !== 0) begin n_fail++; $display("FAIL rule_ct_range got %0d writes want 0", range_viol); end
    endtask

    initial begin
        exp_ct   = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        pt_known = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        for (int a = 0; a < 256; a++) begin
            pt_mem[a] = 8'h00;
            s_mem[a]  = 8'h00;
        end
        test_reset();
        test_known_vector();
        test_zero_length();
        test_round_trip();
        test_busy_en();
        test_mid_reset();
        test_back_to_back();
        test_write_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
